pipeline_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage RV32 pipeline. It merges four event sources and drives per-stage write enables and bubble-insert (flush) controls for every pipeline register:
- the combinational load-use stall from the hazard unit
- the EX-stage taken-branch redirect
- the data-memory wait handshake in MEM
- the multi-cycle MUL/DIV unit in EX

It also keeps a data-memory timeout and saturating performance counters.

---
 rtl/pipeline_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush scheduler for a 5-stage RV32 pipeline. Merges
//               load-use stalls, EX branch redirects, data-memory wait and
//               multi-cycle MUL/DIV into per-stage write/flush controls, with
//               a data-memory timeout and saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  input  logic             md_start,
  input  logic             md_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mem_timeout,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0]       c_st_run     = 2'b00;
  localparam logic [1:0]       c_st_mem     = 2'b01;
  localparam logic [1:0]       c_st_md      = 2'b10;
  localparam logic [TO_W-1:0]  c_to_limit   = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0]  c_to_one     = TO_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max    = '1;

  logic [1:0]      state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            to_q, to_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Next-state and per-stage enable/flush decode (combinational from state and inputs)
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    wait_d       = wait_q;
    to_d         = 1'b0;

    if (!rst_n) begin
      // Hold the whole pipeline in bubbles while reset is asserted
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      state_d      = c_st_run;
      wait_d       = '0;
    end else begin
      case (state_q)
        c_st_mem: begin
          if (dmem_ack) begin
            // Access completes: release with default controls
            state_d = c_st_run;
            wait_d  = '0;
          end else if (wait_q == c_to_limit) begin
            // Memory never answered: force release and flag it next cycle
            state_d = c_st_run;
            wait_d  = '0;
            to_d    = 1'b1;
          end else begin
            // Freeze everything up to EX/MEM, bubble into MEM/WB
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            wait_d       = wait_q + c_to_one;
          end
        end
        c_st_md: begin
          if (md_done) begin
            state_d = c_st_run;
          end else begin
            // Hold front end and EX; MEM sees bubbles, WB drains
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
          end
        end
        default: begin
          if (dmem_req && !dmem_ack) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            state_d      = c_st_mem;
            wait_d       = c_to_one;
          end else if (md_start) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            state_d      = c_st_md;
          end else if (ex_branch_taken) begin
            // Redirect: PC loads the target, the two younger stages are squashed
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (hz_stall) begin
            // Load-use: hold PC and IF/ID, insert one bubble into EX
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  // Saturating performance counter next values
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_write && (stall_q != c_cnt_max)) stall_d = stall_q + c_cnt_one;
    if (if_id_flush && (flush_q != c_cnt_max)) flush_d = flush_q + c_cnt_one;
  end

  // State, wait counter, timeout pulse and perf counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= c_st_run;
      wait_q  <= '0;
      to_q    <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign mem_timeout  = to_q & rst_n;
  assign ctrl_state   = state_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Scoreboard bench for pipeline_ctrl with a rule-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  localparam int TO   = 4;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hz = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0, ms = 1'b0, mdd = 1'b0;
  logic pc_w, ifid_w, idex_w, exmem_w, memwb_w;
  logic ifid_f, idex_f, exmem_f, memwb_f, to_o;
  logic [1:0] st_o;
  logic [CW-1:0] sc_o, fe_o;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hz_stall(hz), .ex_branch_taken(br),
    .dmem_req(req), .dmem_ack(ack), .md_start(ms), .md_done(mdd),
    .pc_write(pc_w), .if_id_write(ifid_w), .id_ex_write(idex_w),
    .ex_mem_write(exmem_w), .mem_wb_write(memwb_w),
    .if_id_flush(ifid_f), .id_ex_flush(idex_f), .ex_mem_flush(exmem_f),
    .mem_wb_flush(memwb_f), .mem_timeout(to_o), .ctrl_state(st_o),
    .stall_cycles(sc_o), .flush_events(fe_o)
  );

  typedef struct packed {
    logic [4:0] wr;   // pc, if_id, id_ex, ex_mem, mem_wb
    logic [3:0] fl;   // if_id, id_ex, ex_mem, mem_wb
    logic       to;
    logic [1:0] st;
    int         sc;
    int         fe;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0 = running, 1 = waiting on memory, 2 = waiting on MUL/DIV
  int mode = 0, waited = 0, stalls = 0, flushes = 0;
  bit to_pend = 0;

  task automatic check(input string name, input int act, input int req_v);
    n_checks++;
    if (act == req_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req_v, $time);
  endtask

  // One cycle: drive inputs, predict this cycle's outputs, advance the model
  task automatic cyc(input bit r, input bit h, input bit b, input bit q,
                     input bit a, input bit s, input bit d);
    exp_t e;
    bit mem_freeze, md_freeze;
    @(posedge clk);
    #1;
    rst_n = r; hz = h; br = b; req = q; ack = a; ms = s; mdd = d;
    e.st = 2'(mode); e.to = to_pend && r; e.sc = stalls; e.fe = flushes;
    e.wr = 5'b11111; e.fl = 4'b0000;
    mem_freeze = 0; md_freeze = 0;
    if (!r) begin
      e.wr = 5'b00000; e.fl = 4'b1111;
      mode = 0; waited = 0; to_pend = 0; stalls = 0; flushes = 0;
    end else begin
      to_pend = 0;
      if (mode == 1) begin
        if (a) begin mode = 0; waited = 0; end
        else if (waited == TO) begin mode = 0; waited = 0; to_pend = 1; end
        else begin mem_freeze = 1; waited++; end
      end else if (mode == 2) begin
        if (d) mode = 0; else md_freeze = 1;
      end else begin
        if (q && !a) begin mem_freeze = 1; mode = 1; waited = 1; end
        else if (s) begin md_freeze = 1; mode = 2; end
        else if (b) e.fl = 4'b1100;
        else if (h) begin e.wr = 5'b00111; e.fl = 4'b0100; end
      end
      if (mem_freeze) begin e.wr = 5'b00001; e.fl = 4'b0001; end
      if (md_freeze)  begin e.wr = 5'b00011; e.fl = 4'b0010; end
      if (!e.wr[4] && stalls < CMAX) stalls++;
      if (e.fl[3] && flushes < CMAX) flushes++;
    end
    sb.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a full control vector
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("writes", int'({pc_w, ifid_w, idex_w, exmem_w, memwb_w}), int'(e.wr));
      check("flushes", int'({ifid_f, idex_f, exmem_f, memwb_f}), int'(e.fl));
      check("mem_timeout", int'(to_o), int'(e.to));
      check("ctrl_state", int'(st_o), int'(e.st));
      check("stall_cycles", int'(sc_o), e.sc);
      check("flush_events", int'(fe_o), e.fe);
    end
  end

  initial begin
    // Reset for two cycles, then idle
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
    // Load-use stall, then stall + branch together
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Memory wait with branch held throughout, ack on the third wait cycle
    repeat (3) cyc(1, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Memory never answers: forced release and timeout pulse
    repeat (6) cyc(1, 0, 0, 1, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    // Ack coincides with timeout limit: ack wins, no pulse
    repeat (4) cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
    // MUL/DIV for five cycles, done on the last
    repeat (5) cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // MUL/DIV interrupted by reset, late done ignored
    repeat (2) cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    // Memory wait interrupted by reset, late ack ignored
    repeat (2) cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    // Saturate both counters
    repeat (CMAX + 6) cyc(1, 1, 0, 0, 0, 0, 0);
    repeat (CMAX + 6) cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) >= 2),
          ($urandom_range(99) < 25), ($urandom_range(99) < 20),
          ($urandom_range(99) < 25), ($urandom_range(99) < 40),
          ($urandom_range(99) < 12), ($urandom_range(99) < 25));
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
